// File: rtl/keypoint_detect_if.sv
`default_nettype none
// ============================================================================
// Module   : keypoint_detect_if
// Brief    : Window input stream and keypoint output stream of keypoint_detect
// Revision : 1.0
// ============================================================================
interface keypoint_detect_if #(
    parameter int DATA_W = 17,
    parameter int XW     = 8,
    parameter int YW     = 8
);
    logic                  in_valid;
    logic                  in_sof;
    logic [9*DATA_W-1:0]   win;
    logic                  kp_valid;
    logic                  kp_ready;
    logic [XW-1:0]         kp_x;
    logic [YW-1:0]         kp_y;
    logic                  kp_pol;

    modport master (
        output in_valid, in_sof, win, kp_ready,
        input  kp_valid, kp_x, kp_y, kp_pol
    );

    modport slave (
        input  in_valid, in_sof, win, kp_ready,
        output kp_valid, kp_x, kp_y, kp_pol
    );
endinterface
`default_nettype wire

// File: rtl/keypoint_detect.sv
`default_nettype none
// ============================================================================
// Module   : keypoint_detect
// Brief    : 3x3 DoG extremum detector with keypoint FIFO and per-frame count
// Revision : 1.0
// ============================================================================
module keypoint_detect #(
    parameter int DATA_W = 17,
    parameter int IMG_W  = 256,
    parameter int IMG_H  = 256,
    parameter int BORDER = 1,
    parameter int DEPTH  = 16,
    parameter int XW     = $clog2(IMG_W),
    parameter int YW     = $clog2(IMG_H)
) (
    input  wire logic                  clk,
    input  wire logic                  rst,
    keypoint_detect_if.slave           bus,
    input  wire logic [DATA_W-1:0]     thresh,
    input  wire logic [1:0]            mode,
    output logic [$clog2(DEPTH):0]     kp_level,
    output logic                       overflow,
    output logic [15:0]                frame_kp_count
);
    localparam int             c_AW     = $clog2(DEPTH);
    localparam int             c_EW     = XW + YW + 1;
    localparam logic [XW-1:0]  c_X_LAST = XW'(IMG_W - 1);
    localparam logic [YW-1:0]  c_Y_LAST = YW'(IMG_H - 1);
    localparam logic [XW-1:0]  c_X_LO   = XW'(BORDER);
    localparam logic [XW-1:0]  c_X_HI   = XW'(IMG_W - 1 - BORDER);
    localparam logic [YW-1:0]  c_Y_LO   = YW'(BORDER);
    localparam logic [YW-1:0]  c_Y_HI   = YW'(IMG_H - 1 - BORDER);
    localparam logic [c_AW:0]  c_FULL   = (c_AW + 1)'(DEPTH);

    // ------------------------------------------------------------------
    // Window unpack and extremum test
    // ------------------------------------------------------------------
    logic signed [DATA_W-1:0] w_pix [9];

    for (genvar gi = 0; gi < 9; gi++) begin : g_unpack
        assign w_pix[gi] = bus.win[gi*DATA_W +: DATA_W];
    end

    // One extra bit so that -thresh is representable for every thresh value
    logic signed [DATA_W:0] w_centre_x;
    logic signed [DATA_W:0] w_thresh_x;
    logic signed [DATA_W:0] w_neg_thresh;

    assign w_centre_x   = {w_pix[4][DATA_W-1], w_pix[4]};
    assign w_thresh_x   = {1'b0, thresh};
    assign w_neg_thresh = -w_thresh_x;

    logic w_gt_all;
    logic w_lt_all;

    always_comb begin
        w_gt_all = 1'b1;
        w_lt_all = 1'b1;
        for (int i = 0; i < 9; i++) begin
            if (i != 4) begin
                if (!(w_pix[4] > w_pix[i])) w_gt_all = 1'b0;
                if (!(w_pix[4] < w_pix[i])) w_lt_all = 1'b0;
            end
        end
    end

    logic w_is_max;
    logic w_is_min;

    assign w_is_max = w_gt_all && (w_centre_x > w_thresh_x);
    assign w_is_min = w_lt_all && (w_centre_x < w_neg_thresh);

    // ------------------------------------------------------------------
    // Pixel position; start-of-frame overrides the running counters
    // ------------------------------------------------------------------
    logic [XW-1:0] r_x;
    logic [YW-1:0] r_y;
    logic [XW-1:0] w_cur_x;
    logic [YW-1:0] w_cur_y;

    assign w_cur_x = bus.in_sof ? '0 : r_x;
    assign w_cur_y = bus.in_sof ? '0 : r_y;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_x <= '0;
            r_y <= '0;
        end else if (bus.in_valid) begin
            if (w_cur_x == c_X_LAST) begin
                r_x <= '0;
                r_y <= (w_cur_y == c_Y_LAST) ? '0 : w_cur_y + YW'(1);
            end else begin
                r_x <= w_cur_x + XW'(1);
                r_y <= w_cur_y;
            end
        end
    end

    logic w_border;
    logic w_hit;

    assign w_border = (w_cur_x < c_X_LO) || (w_cur_x > c_X_HI) ||
                      (w_cur_y < c_Y_LO) || (w_cur_y > c_Y_HI);

    assign w_hit = bus.in_valid && !w_border &&
                   ((mode[0] && w_is_max) || (mode[1] && w_is_min));

    // ------------------------------------------------------------------
    // Stage 1: registered hit
    // ------------------------------------------------------------------
    logic          r_hit;
    logic [XW-1:0] r_hit_x;
    logic [YW-1:0] r_hit_y;
    logic          r_hit_pol;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hit     <= 1'b0;
            r_hit_x   <= '0;
            r_hit_y   <= '0;
            r_hit_pol <= 1'b0;
        end else begin
            r_hit     <= w_hit;
            r_hit_x   <= w_cur_x;
            r_hit_y   <= w_cur_y;
            r_hit_pol <= w_is_max;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: keypoint FIFO
    // ------------------------------------------------------------------
    logic [c_EW-1:0] r_mem [DEPTH];
    logic [c_AW:0]   r_wr_ptr;
    logic [c_AW:0]   r_rd_ptr;
    logic [c_EW-1:0] w_head;
    logic            w_full;
    logic            w_pop;
    logic            w_push;

    assign kp_level     = r_wr_ptr - r_rd_ptr;
    assign w_full       = (kp_level == c_FULL);
    assign bus.kp_valid = (kp_level != '0);
    assign w_pop        = bus.kp_valid && bus.kp_ready;
    // A pop on the same edge frees the slot the write needs
    assign w_push       = r_hit && (!w_full || w_pop);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[c_AW-1:0]] <= {r_hit_x, r_hit_y, r_hit_pol};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            overflow <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + (c_AW + 1)'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + (c_AW + 1)'(1);
            if (r_hit && w_full && !w_pop) overflow <= 1'b1;
        end
    end

    // Head is masked while empty so the outputs read zero out of reset
    assign w_head     = r_mem[r_rd_ptr[c_AW-1:0]];
    assign bus.kp_x   = bus.kp_valid ? w_head[c_EW-1 -: XW] : '0;
    assign bus.kp_y   = bus.kp_valid ? w_head[YW:1]         : '0;
    assign bus.kp_pol = bus.kp_valid ? w_head[0]            : 1'b0;

    // ------------------------------------------------------------------
    // Per-frame keypoint count (dropped hits are still counted)
    // ------------------------------------------------------------------
    logic [15:0] r_run;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_run          <= '0;
            frame_kp_count <= '0;
        end else if (bus.in_valid && bus.in_sof) begin
            frame_kp_count <= r_run;
            r_run          <= r_hit ? 16'd1 : 16'd0;
        end else if (r_hit && (r_run != 16'hFFFF)) begin
            r_run <= r_run + 16'd1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_keypoint_detect.sv
`default_nettype none
// ============================================================================
// Module   : tb_keypoint_detect
// Brief    : Scoreboard bench for keypoint_detect on an 8x8 image, DEPTH 4
// Revision : 1.0
// ============================================================================
module tb_keypoint_detect;
    localparam int DW = 17;
    localparam int IW = 8;
    localparam int IH = 8;
    localparam int BD = 1;
    localparam int DP = 4;
    localparam int XW = 3;
    localparam int YW = 3;

    typedef struct {
        int x;
        int y;
        int pol;
    } kp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [DW-1:0] thresh = '0;
    logic [1:0]    mode = 2'b11;
    logic [2:0]    kp_level;
    logic          overflow;
    logic [15:0]   frame_kp_count;

    always #5 clk = ~clk;

    keypoint_detect_if #(.DATA_W(DW), .XW(XW), .YW(YW)) bus ();

    keypoint_detect #(
        .DATA_W(DW), .IMG_W(IW), .IMG_H(IH), .BORDER(BD), .DEPTH(DP),
        .XW(XW), .YW(YW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .bus            (bus),
        .thresh         (thresh),
        .mode           (mode),
        .kp_level       (kp_level),
        .overflow       (overflow),
        .frame_kp_count (frame_kp_count)
    );

    int  checks = 0;
    int  errors = 0;
    kp_t sb[$];

    // Reference model state
    int  wv [9];
    int  mlev, movf, mrun, mframe, px, py;
    bit  pend;
    kp_t pend_e;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [9*DW-1:0] pack_win();
        logic [9*DW-1:0] w;
        for (int i = 0; i < 9; i++) w[i*DW +: DW] = DW'(wv[i]);
        return w;
    endfunction

    task automatic set_win(input int c, input int n);
        for (int i = 0; i < 9; i++) wv[i] = n;
        wv[4] = c;
    endtask

    task automatic rand_win();
        int c;
        int k;
        c = $urandom_range(0, 4000);
        c = c - 2000;
        k = $urandom_range(0, 7);
        if (k == 7) c = ($urandom_range(0, 1) == 1) ? 65535 : -65536;
        wv[4] = c;
        for (int i = 0; i < 9; i++) begin
            if (i != 4) begin
                if (k < 3)      wv[i] = c - int'($urandom_range(0, 40));
                else if (k < 5) wv[i] = c + int'($urandom_range(0, 40));
                else            wv[i] = int'($urandom_range(0, 4000)) - 2000;
            end
        end
    endtask

    task automatic model_reset();
        mlev = 0; movf = 0; mrun = 0; mframe = 0; px = 0; py = 0; pend = 0;
        pend_e = '{0, 0, 0};
        sb.delete();
    endtask

    // One input beat: update the model for the coming edge, then check after it
    task automatic beat(input bit v, input bit sof, input bit rdy);
        bit pop;
        bit hit;
        bit mx;
        bit mn;
        bit brd;
        int cx;
        int cy;
        int c;
        int th;
        bus.in_valid = v;
        bus.in_sof   = sof;
        bus.win      = pack_win();
        bus.kp_ready = rdy;
        pop = (mlev > 0) && rdy;
        if (pend) begin
            if (mlev == DP && !pop) movf = 1;
            else begin
                sb.push_back(pend_e);
                mlev++;
            end
        end
        if (pop) mlev--;
        if (v && sof) begin
            mframe = mrun;
            mrun   = pend ? 1 : 0;
        end else if (pend && mrun < 65535) mrun++;
        hit = 0;
        if (v) begin
            cx = sof ? 0 : px;
            cy = sof ? 0 : py;
            c  = wv[4];
            th = int'(thresh);
            mx = (c > th);
            mn = (c < -th);
            for (int i = 0; i < 9; i++) begin
                if (i != 4) begin
                    if (!(c > wv[i])) mx = 0;
                    if (!(c < wv[i])) mn = 0;
                end
            end
            brd = (cx < BD) || (cx > IW-1-BD) || (cy < BD) || (cy > IH-1-BD);
            hit = !brd && ((mode[0] && mx) || (mode[1] && mn));
            pend_e = '{cx, cy, mx ? 1 : 0};
            px = cx + 1;
            py = cy;
            if (px == IW) begin
                px = 0;
                py = (cy + 1 == IH) ? 0 : cy + 1;
            end
        end
        pend = hit;
        @(posedge clk);
        #1;
        check("kp_valid", bus.kp_valid, (mlev > 0) ? 1 : 0);
        check("kp_level", kp_level, mlev);
        check("overflow", overflow, movf);
        check("frame_kp_count", frame_kp_count, mframe);
    endtask

    // Monitor: every handshake pops the scoreboard head
    always @(negedge clk) begin
        kp_t e;
        if (rst === 1'b1 && bus.kp_valid === 1'b1 && bus.kp_ready === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_kp", 1, 0);
            end else begin
                e = sb.pop_front();
                check("kp_x", bus.kp_x, e.x);
                check("kp_y", bus.kp_y, e.y);
                check("kp_pol", bus.kp_pol, e.pol);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int x;
        int y;
        bus.in_valid = 0;
        bus.in_sof   = 0;
        bus.win      = '0;
        bus.kp_ready = 0;
        model_reset();
        #2;
        check("rst_kp_valid", bus.kp_valid, 0);
        check("rst_kp_level", kp_level, 0);
        check("rst_overflow", overflow, 0);
        check("rst_frame_cnt", frame_kp_count, 0);
        check("rst_kp_xyp", {bus.kp_x, bus.kp_y, bus.kp_pol}, 0);
        #20 rst = 1'b1;
        @(posedge clk);
        #1;

        // Directed frame: placement, border, polarity, mode, strictness
        thresh = 100;
        for (int p = 0; p < IW*IH; p++) begin
            x = p % IW;
            y = p / IW;
            set_win(0, 0);
            mode = 2'b11;
            if (x == 3 && y == 2) set_win(500, 0);
            if (x == 0 && y == 5) set_win(500, 0);
            if (x == 7 && y == 7) set_win(500, 0);
            if (x == 4 && y == 4) set_win(-500, 0);
            if (x == 5 && y == 3) set_win(100, 0);
            if (x == 2 && y == 2) begin set_win(500, 0); wv[0] = 500; end
            if (x == 5 && y == 5) begin set_win(-500, 0); mode = 2'b01; end
            beat(1, p == 0, 1);
        end
        mode = 2'b11;

        // Frame with six interior hits
        for (int p = 0; p < IW*IH; p++) begin
            x = p % IW;
            y = p / IW;
            set_win(0, 0);
            if (y == 3 && x >= 1 && x <= 6) set_win((x % 2 == 0) ? 700 : -700, 0);
            beat(1, p == 0, 1);
        end

        // Fill and overflow with the consumer stalled, then pop-with-push
        for (int p = 0; p < IW*IH; p++) begin
            x = p % IW;
            y = p / IW;
            set_win(0, 0);
            if (y == 1 && x >= 1 && x <= 6) set_win(300, 0);
            beat(1, p == 0, !(y < 1 || (y == 1 && x < 7)));
        end

        // Queue three entries, put one more hit in flight, then reset
        for (int p = 0; p < 12; p++) begin
            x = p % IW;
            set_win(0, 0);
            if (p >= 9 && p <= 12) set_win(-300, 0);
            if (x >= 1 && p >= 9) set_win(-300, 0);
            beat(1, p == 0, 0);
        end
        set_win(-300, 0);
        beat(1, 0, 0);
        rst = 1'b0;
        bus.in_valid = 0;
        #2;
        check("mid_rst_kp_valid", bus.kp_valid, 0);
        check("mid_rst_kp_level", kp_level, 0);
        check("mid_rst_overflow", overflow, 0);
        model_reset();
        @(negedge clk);
        #2 rst = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_kp_level", kp_level, 0);

        // Randomised frames
        for (int f = 0; f < 4; f++) begin
            thresh = ($urandom_range(0, 9) == 0) ? {DW{1'b1}} : DW'($urandom_range(0, 1500));
            for (int p = 0; p < IW*IH; p++) begin
                bit v;
                if ($urandom_range(0, 7) == 0) mode = 2'($urandom_range(0, 3));
                rand_win();
                v = (p == 0) || ($urandom_range(0, 4) != 0);
                beat(v, p == 0, $urandom_range(0, 9) < 7);
                if (!v) p--;
            end
        end

        for (int i = 0; i < 40 && sb.size() > 0; i++) beat(0, 0, 1);
        beat(0, 0, 1);
        check("scoreboard_drained", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
